// File: rtl/pipe_share_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_share_pkg                                               |
// | Description : Shared constants and width helpers for the pipeline-lane     |
// |               sharing scheduler (id / counter width derivation).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_share_pkg;

  // Ceiling log2 for elaboration-time width calculation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Requester index width; at least one bit so a single-bit port always exists.
  function automatic int id_width(input int n_req);
    return (clog2(n_req) < 1) ? 1 : clog2(n_req);
  endfunction

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

  // Pointer width for a ring of 'depth' entries; at least one bit.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_share_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_share_fifo                                              |
// | Description : Synchronous FIFO holding returned {id, data} responses.      |
// |               Any depth is supported; pointers wrap at DEPTH. Head data    |
// |               reads as zero while empty.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_share_fifo
  import pipe_share_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 8,
  localparam int c_CW = cnt_width(DEPTH),
  localparam int c_PW = ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr,
  input  logic [W-1:0]    i_wdata,
  input  logic            i_rd,
  output logic [W-1:0]    o_rdata,
  output logic            o_empty,
  output logic [c_CW-1:0] o_count
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_full;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == c_CW'(DEPTH));
  assign w_wr_en = i_wr && !w_full;
  assign w_rd_en = i_rd && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; contents need no reset because the count guards every read.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping; a simultaneous write and read keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == c_PW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PW'(1);
      if (w_rd_en) r_rd_ptr <= (r_rd_ptr == c_PW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit control must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_wr && w_full));

endmodule
`default_nettype wire

// File: rtl/pipe_share_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_share_sched                                             |
// | Description : Shares one free-running M-bit, N-stage data pipeline among R |
// |               requesters: round-robin arbiter, valid/id tag shadow pipe,   |
// |               credit counter and a response FIFO for backpressure.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_share_sched
  import pipe_share_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 4,
  parameter int R = 4,
  parameter int F = 8,
  localparam int c_IDW = id_width(R),
  localparam int c_CW  = cnt_width(F)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     i_req_valid,
  input  logic [R*M-1:0]   i_req_data,
  output logic [R-1:0]     o_req_ready,
  output logic [M-1:0]     o_pipe_in,
  input  logic [M-1:0]     i_pipe_out,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [M-1:0]     o_rsp_data,
  output logic [c_IDW-1:0] o_rsp_id,
  output logic [c_CW-1:0]  o_inflight
);

  // Validity and source of each item travelling alongside the data lane.
  typedef struct packed {
    logic             valid;
    logic [c_IDW-1:0] id;
  } tag_t;

  logic [c_IDW-1:0] r_rr_ptr;
  logic [c_CW-1:0]  r_inflight;
  tag_t             r_tag [N];

  logic             w_credit_ok;
  logic             w_found;
  logic [c_IDW-1:0] w_winner;
  logic             w_grant;
  logic             w_pop;
  tag_t             w_tag_in;
  logic             w_fifo_wr;
  logic [c_IDW+M-1:0] w_fifo_wdata;
  logic [c_IDW+M-1:0] w_fifo_rdata;
  logic             w_fifo_empty;
  logic [c_CW-1:0]  w_fifo_count;

  // Credit comes only from registered occupancy, so a pop frees a slot one cycle later.
  assign w_credit_ok = (r_inflight < c_CW'(F));

  // Round-robin pick: first valid at or above rr_ptr, otherwise lowest valid below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < R; i++) begin
      if (!w_found && i_req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_found  = 1'b1;
        w_winner = c_IDW'(i);
      end
    end
    for (int i = 0; i < R; i++) begin
      if (!w_found && i_req_valid[i]) begin
        w_found  = 1'b1;
        w_winner = c_IDW'(i);
      end
    end
  end

  // Reset also masks the grant so nothing is offered while the block is held.
  assign w_grant = w_found && w_credit_ok && rst_n;

  // One-hot ready and payload steering onto the lane; idle lane carries zero.
  always_comb begin
    o_req_ready = '0;
    o_pipe_in   = '0;
    for (int i = 0; i < R; i++) begin
      if (w_grant && (int'(w_winner) == i)) begin
        o_req_ready[i] = 1'b1;
        o_pipe_in      = i_req_data[i*M +: M];
      end
    end
  end

  // Tag entering the shadow pipe this cycle.
  always_comb begin
    w_tag_in = '0;
    if (w_grant) begin
      w_tag_in.valid = 1'b1;
      w_tag_in.id    = w_winner;
    end
  end

  // Round-robin pointer moves just past the winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_winner == c_IDW'(R - 1)) ? '0 : w_winner + c_IDW'(1);
    end
  end

  // Tag shadow pipe shifts every cycle, matching the free-running data lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < N; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // The last tag lines up with the lane output; only valid slots enter the FIFO.
  assign w_fifo_wr    = r_tag[N-1].valid;
  assign w_fifo_wdata = {r_tag[N-1].id, i_pipe_out};
  assign w_pop        = o_rsp_valid && i_rsp_ready;

  pipe_share_fifo #(
    .W     (c_IDW + M),
    .DEPTH (F)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_fifo_wr),
    .i_wdata (w_fifo_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_rsp_valid = !w_fifo_empty;
  assign o_rsp_data  = w_fifo_rdata[M-1:0];
  assign o_rsp_id    = w_fifo_rdata[c_IDW+M-1:M];
  assign o_inflight  = r_inflight;

  // Items in the lane plus queued responses: +1 per grant, -1 per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_grant, w_pop})
        2'b10:   r_inflight <= r_inflight + c_CW'(1);
        2'b01:   r_inflight <= r_inflight - c_CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Queued entries are a subset of everything in flight.
  a_count_in_credit: assert property (@(posedge clk) disable iff (!rst_n)
                                      (r_inflight >= w_fifo_count) && (r_inflight <= c_CW'(F)));

endmodule
`default_nettype wire

// File: tb/tb_pipe_share_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_share_sched                                          |
// | Description : Self-checking bench for pipe_share_sched with an N-stage     |
// |               free-running lane and an in-order response scoreboard.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_share_sched;

  localparam int M   = 3;
  localparam int N   = 4;
  localparam int R   = 4;
  localparam int F   = 8;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [R-1:0]     req_valid;
  logic [R*M-1:0]   req_data;
  logic [R-1:0]     req_ready;
  logic [M-1:0]     pipe_in;
  logic [M-1:0]     pipe_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [M-1:0]     rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic [CW-1:0]    inflight;

  always #5 clk = ~clk;

  pipe_share_sched #(.M(M), .N(N), .R(R), .F(F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_pipe_in   (pipe_in),
    .i_pipe_out  (pipe_out),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_inflight  (inflight)
  );

  // Free-running data lane with no reset; starts with junk to expose stale data.
  logic [M-1:0] lane [1:N];
  initial for (int i = 1; i <= N; i++) lane[i] = M'(i + 2);
  always @(posedge clk) begin
    lane[1] <= pipe_in;
    for (int i = 2; i <= N; i++) lane[i] <= lane[i-1];
  end
  assign pipe_out = lane[N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: source, payload and first cycle it may appear at the head.
  typedef struct {
    int id;
    int data;
    int due;
  } sb_t;
  sb_t sb[$];

  int m_rr       = 0;
  int m_inflight = 0;
  int m_grants   = 0;
  int m_win;
  int idx;
  logic [R-1:0]   tmp_v;
  logic [R*M-1:0] tmp_d;
  logic [R-1:0]   exp_ready;
  logic [M-1:0]   exp_pin;
  bit             exp_rv;
  sb_t            ent;

  // Cycle model: evaluated mid-cycle, commits what the next rising edge will do.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check_eq("rst_ready",     32'(req_ready), 32'd0);
      check_eq("rst_pipe_in",   32'(pipe_in),   32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
      check_eq("rst_rsp_id",    32'(rsp_id),    32'd0);
      check_eq("rst_inflight",  32'(inflight),  32'd0);
      sb.delete();
      m_rr       = 0;
      m_inflight = 0;
    end else begin
      m_win = -1;
      if (m_inflight < F) begin
        for (int k = 0; k < R; k++) begin
          idx   = (m_rr + k) % R;
          tmp_v = req_valid >> idx;
          if (m_win < 0 && tmp_v[0]) m_win = idx;
        end
      end
      exp_ready = '0;
      exp_pin   = '0;
      if (m_win >= 0) begin
        exp_ready = R'(1) << m_win;
        tmp_d     = req_data >> (m_win * M);
        exp_pin   = tmp_d[M-1:0];
      end
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("pipe_in",   32'(pipe_in),   32'(exp_pin));
      check_eq("inflight",  32'(inflight),  32'(m_inflight));
      check_eq("inflight_le_F", 32'(inflight <= CW'(F)), 32'd1);
      exp_rv = (sb.size() > 0) && (sb[0].due <= cyc);
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check_eq("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        check_eq("rsp_id",   32'(rsp_id),   32'(sb[0].id));
        if (rsp_ready) begin
          void'(sb.pop_front());
          m_inflight--;
        end
      end
      if (m_win >= 0) begin
        ent.id   = m_win;
        ent.data = int'(exp_pin);
        ent.due  = cyc + N + 1;
        sb.push_back(ent);
        m_rr = (m_win + 1) % R;
        m_inflight++;
        m_grants++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int g0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset state, with requests asserted to show they are not granted.
    req_valid = 4'b1111;
    peek();
    check_eq("reset_ready",    32'(req_ready), 32'd0);
    check_eq("reset_inflight", 32'(inflight),  32'd0);
    check_eq("reset_rspvalid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single request: response exactly N+1 cycles after the grant.
    req_valid = 4'b0001;
    req_data  = 12'h005;
    rsp_ready = 1'b1;
    peek();
    check_eq("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    for (int k = 1; k <= N + 1; k++) begin
      peek();
      if (k <= N) begin
        check_eq("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
      end else begin
        check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t1_rsp_data",  32'(rsp_data),  32'd5);
        check_eq("t1_rsp_id",    32'(rsp_id),    32'd0);
      end
      tick();
    end

    // All requesting with no backpressure: strict rotation, no bubbles.
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      req_data = 12'($urandom);
      peek();
      check_eq("t2_rotation", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= N + 1) begin
        check_eq("t2_no_bubble", 32'(rsp_valid), 32'd1);
        check_eq("t2_rsp_order", 32'(rsp_id), 32'((k - N - 1) % 4));
      end
      tick();
    end

    // Saturation with rsp_ready low: exactly F grants, then one per pop.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    g0 = m_grants;
    for (int k = 0; k < 16; k++) begin
      req_data = 12'($urandom);
      tick();
    end
    peek();
    check_eq("t3_grants",   32'(m_grants - g0), 32'(F));
    check_eq("t3_stall",    32'(req_ready),     32'd0);
    check_eq("t3_inflight", 32'(inflight),      32'(F));
    tick();
    rsp_ready = 1'b1;
    peek();
    check_eq("t3_credit_lag", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    peek();
    check_eq("t3_regrant", 32'(req_ready != '0), 32'd1);
    tick();
    peek();
    check_eq("t3_stall2",  32'(req_ready),     32'd0);
    check_eq("t3_grants2", 32'(m_grants - g0), 32'(F + 1));
    tick();

    // Round-robin wrap from the last requester back to requester 0.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    peek();
    check_eq("t4_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1001;
    peek();
    check_eq("t4_grant3", 32'(req_ready), 32'b1000);
    tick();
    peek();
    check_eq("t4_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;

    // Reset with two queued and three in the lane drops everything.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = 12'h003;
    tick();
    tick();
    req_valid = '0;
    repeat (N + 1) tick();
    req_valid = 4'b0010;
    req_data  = 12'h038;
    repeat (3) tick();
    req_valid = '0;
    peek();
    check_eq("t5_inflight_pre", 32'(inflight),  32'd5);
    check_eq("t5_rsp_pre",      32'(rsp_valid), 32'd1);
    tick();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("t5_async_rsp",      32'(rsp_valid), 32'd0);
    check_eq("t5_async_inflight", 32'(inflight),  32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      peek();
      check_eq("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Random traffic against the scoreboard.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      req_valid = 4'($urandom);
      req_data  = 12'($urandom);
      if (k < 3000)      rsp_ready = ($urandom_range(0, 3) != 0);
      else if (k < 6000) rsp_ready = ($urandom_range(0, 3) == 0);
      else               rsp_ready = 1'($urandom);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3 * F + N) tick();
    peek();
    check_eq("t6_drained_sb",       32'(sb.size()), 32'd0);
    check_eq("t6_drained_inflight", 32'(inflight),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
